// File: rtl/srec_loader.sv
// srec_loader: parses an ASCII Motorola S-record stream one character at a
// time and issues byte writes to main memory, holding the fetch pipeline in
// stall until a termination record (S7/S8/S9) or end-of-stream (0xFF).
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   char_valid, char_in    character source (accepted when char_ready is high)
//   char_ready             loader accepts char_in on this edge
//   srec_address/_data_in  byte write address / data (byte in [7:0])
//   srec_access_size       always 2'b00 (byte)
//   srec_rw                one-cycle write strobe
//   srec_parse, stall      loading in progress / fetch hold
//   start_pc               entry address from the termination record
//   done, err, err_code    sticky status (01 checksum, 10 illegal, 11 count)
module srec_loader #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    input  logic [7:0]        char_in,
    output logic              char_ready,
    output logic [ADDR_W-1:0] srec_address,
    output logic [DATA_W-1:0] srec_data_in,
    output logic [1:0]        srec_access_size,
    output logic              srec_rw,
    output logic              srec_parse,
    output logic              stall,
    output logic [ADDR_W-1:0] start_pc,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [3:0] {
        S_IDLE, S_TYPE, S_CNT_HI, S_CNT_LO, S_ADDR, S_DATA,
        S_WRITE, S_CSUM, S_EOL, S_DONE, S_ERROR
    } state_e;

    state_e            state_q;
    logic              ready_q, rw_q, parse_q, stall_q, done_q, err_q;
    logic [1:0]        err_code_q;
    logic [ADDR_W-1:0] waddr_q, addr_q, offset_q, start_pc_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        type_q, nib_hi_q, anib_q;
    logic [7:0]        abytes_q, cnt_q, rem_q, sum_q;
    logic              phase_q;

    // Character decode
    logic       is_hex, is_digit, accept, write_type, term_type;
    logic [3:0] nib;
    logic [7:0] byte_val;

    always_comb begin
        is_hex   = 1'b0;
        is_digit = 1'b0;
        nib      = '0;
        if (char_in >= 8'h30 && char_in <= 8'h39) begin
            is_hex   = 1'b1;
            is_digit = 1'b1;
            nib      = char_in[3:0];
        end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                     (char_in >= 8'h61 && char_in <= 8'h66)) begin
            is_hex = 1'b1;
            nib    = char_in[3:0] + 4'd9;
        end
        byte_val   = {nib_hi_q, nib};
        accept     = char_valid & ready_q;
        write_type = (type_q == 4'd1) || (type_q == 4'd2) || (type_q == 4'd3);
        term_type  = (type_q == 4'd7) || (type_q == 4'd8) || (type_q == 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            rw_q       <= 1'b0;
            parse_q    <= 1'b1;
            stall_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            offset_q   <= '0;
            start_pc_q <= '0;
            type_q     <= '0;
            nib_hi_q   <= '0;
            anib_q     <= '0;
            abytes_q   <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            sum_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            rw_q    <= 1'b0;
            if (state_q == S_WRITE) begin
                state_q <= (rem_q == 8'd0) ? S_CSUM : S_DATA;
            end else if (accept && char_in != 8'h0D &&
                         state_q != S_DONE && state_q != S_ERROR) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (char_in == 8'h53) begin
                            state_q  <= S_TYPE;
                            addr_q   <= '0;
                            offset_q <= '0;
                            phase_q  <= 1'b0;
                        end else if (char_in == 8'hFF) begin
                            state_q <= S_DONE;
                            parse_q <= 1'b0;
                            stall_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (char_in != 8'h0A) begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_TYPE: begin
                        if (is_digit && nib != 4'd4 && nib != 4'd6) begin
                            type_q  <= nib;
                            state_q <= S_CNT_HI;
                            case (nib)
                                4'd2, 4'd8: begin anib_q <= 4'd6; abytes_q <= 8'd3; end
                                4'd3, 4'd7: begin anib_q <= 4'd8; abytes_q <= 8'd4; end
                                default:    begin anib_q <= 4'd4; abytes_q <= 8'd2; end
                            endcase
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_CNT_HI: begin
                        if (is_hex) begin
                            nib_hi_q <= nib;
                            state_q  <= S_CNT_LO;
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_CNT_LO: begin
                        if (is_hex) begin
                            cnt_q   <= byte_val;
                            sum_q   <= byte_val;
                            state_q <= S_ADDR;
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_ADDR: begin
                        if (is_hex) begin
                            addr_q <= {addr_q[ADDR_W-5:0], nib};
                            anib_q <= anib_q - 4'd1;
                            // Odd remaining nibble count means this nibble closes a byte.
                            if (anib_q[0]) sum_q <= sum_q + byte_val;
                            else           nib_hi_q <= nib;
                            if (anib_q == 4'd1) begin
                                if (cnt_q <= abytes_q) begin
                                    state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b11;
                                end else begin
                                    rem_q   <= cnt_q - abytes_q - 8'd1;
                                    state_q <= (cnt_q == abytes_q + 8'd1) ? S_CSUM : S_DATA;
                                end
                            end
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_DATA: begin
                        if (is_hex) begin
                            phase_q <= ~phase_q;
                            if (!phase_q) begin
                                nib_hi_q <= nib;
                            end else begin
                                sum_q <= sum_q + byte_val;
                                rem_q <= rem_q - 8'd1;
                                if (write_type) begin
                                    state_q  <= S_WRITE;
                                    rw_q     <= 1'b1;
                                    ready_q  <= 1'b0;
                                    waddr_q  <= addr_q + offset_q;
                                    wdata_q  <= DATA_W'(byte_val);
                                    offset_q <= offset_q + 1'b1;
                                end else if (rem_q == 8'd1) begin
                                    state_q <= S_CSUM;
                                end
                            end
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_CSUM: begin
                        if (is_hex) begin
                            phase_q <= ~phase_q;
                            if (!phase_q) begin
                                nib_hi_q <= nib;
                            end else if (byte_val == ~sum_q) begin
                                state_q <= S_EOL;
                            end else begin
                                state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b01;
                            end
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    S_EOL: begin
                        if (char_in == 8'h0A) begin
                            if (term_type) begin
                                state_q    <= S_DONE;
                                start_pc_q <= addr_q;
                                parse_q    <= 1'b0;
                                stall_q    <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign char_ready       = ready_q;
    assign srec_address     = waddr_q;
    assign srec_data_in     = wdata_q;
    assign srec_access_size = 2'b00;
    assign srec_rw          = rw_q;
    assign srec_parse       = parse_q;
    assign stall            = stall_q;
    assign start_pc         = start_pc_q;
    assign done             = done_q;
    assign err              = err_q;
    assign err_code         = err_code_q;

endmodule

// File: tb/tb_srec_loader.sv
// tb_srec_loader: randomized S-record streams checked against a record-level
// reference model (expected write list, start PC, status flags).
module tb_srec_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_ready;
    logic [31:0] srec_address, srec_data_in, start_pc;
    logic [1:0]  srec_access_size, err_code;
    logic        srec_rw, srec_parse, stall, done, err;

    srec_loader #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_in(char_in),
        .char_ready(char_ready), .srec_address(srec_address),
        .srec_data_in(srec_data_in), .srec_access_size(srec_access_size),
        .srec_rw(srec_rw), .srec_parse(srec_parse), .stall(stall),
        .start_pc(start_pc), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream_q[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [31:0] got_addr[$], got_data[$];
    logic [1:0]  got_size[$];
    int          got_base = 0;
    bit          count_en = 1'b0;
    int          bubbles = 0;

    // Write capture and back-pressure bubble count, sampled mid-cycle
    always @(negedge clk) begin
        if (srec_rw) begin
            got_addr.push_back(srec_address);
            got_data.push_back(srec_data_in);
            got_size.push_back(srec_access_size);
        end
        if (count_en && !rst && !char_ready) bubbles++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [7:0] base;
        base = ($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41;
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return base + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_hex(input logic [7:0] b);
        stream_q.push_back(hexc(b[7:4]));
        stream_q.push_back(hexc(b[3:0]));
    endtask

    task automatic push_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            stream_q.push_back(c);
        end
    endtask

    // Builds one well-formed record; returns the (masked) record address.
    task automatic build_rec(input int t, input logic [31:0] a_in, input int n,
                             input bit crlf, output logic [31:0] a);
        int         ab;
        logic [7:0] sum, cnt, d;
        ab  = (t == 2 || t == 8) ? 3 : ((t == 3 || t == 7) ? 4 : 2);
        a   = a_in & (32'hFFFF_FFFF >> (8 * (4 - ab)));
        cnt = 8'(ab + n + 1);
        sum = cnt;
        stream_q.push_back(8'h53);
        stream_q.push_back(8'h30 + 8'(t));
        push_hex(cnt);
        for (int k = ab - 1; k >= 0; k--) begin
            d = 8'(a >> (8 * k));
            sum += d;
            push_hex(d);
        end
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            sum += d;
            push_hex(d);
            if (t >= 1 && t <= 3) begin
                exp_addr.push_back(a + 32'(i));
                exp_data.push_back({24'h0, d});
            end
        end
        push_hex(~sum);
        if (crlf) stream_q.push_back(8'h0D);
        stream_q.push_back(8'h0A);
    endtask

    task automatic send_char(input logic [7:0] c);
        bit took;
        took = 1'b0;
        char_valid = 1'b1;
        char_in = c;
        for (int k = 0; k < 20 && !took; k++) begin
            took = char_ready;
            @(posedge clk);
            #1;
        end
        if (!took) check_eq("send_timeout", {63'h0, took}, 64'h1);
    endtask

    task automatic send_stream();
        while (stream_q.size() > 0) send_char(stream_q.pop_front());
        char_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_expect();
        exp_addr.delete();
        exp_data.delete();
        stream_q.delete();
        got_base = got_addr.size();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        char_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_expect();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, {63'h0, char_ready}, 64'h0);
        check_eq({tag, "_addr"}, {32'h0, srec_address}, 64'h0);
        check_eq({tag, "_data"}, {32'h0, srec_data_in}, 64'h0);
        check_eq({tag, "_size"}, {62'h0, srec_access_size}, 64'h0);
        check_eq({tag, "_rw"}, {63'h0, srec_rw}, 64'h0);
        check_eq({tag, "_parse"}, {63'h0, srec_parse}, 64'h1);
        check_eq({tag, "_stall"}, {63'h0, stall}, 64'h1);
        check_eq({tag, "_pc"}, {32'h0, start_pc}, 64'h0);
        check_eq({tag, "_done"}, {63'h0, done}, 64'h0);
        check_eq({tag, "_err"}, {63'h0, err}, 64'h0);
        check_eq({tag, "_code"}, {62'h0, err_code}, 64'h0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        n = got_addr.size() - got_base;
        check_eq({tag, "_wcount"}, 64'(n), 64'(exp_addr.size()));
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            check_eq({tag, "_waddr"}, {32'h0, got_addr[got_base + i]}, {32'h0, exp_addr[i]});
            check_eq({tag, "_wdata"}, {32'h0, got_data[got_base + i]}, {32'h0, exp_data[i]});
            check_eq({tag, "_wsize"}, {62'h0, got_size[got_base + i]}, 64'h0);
        end
    endtask

    initial begin
        int          tl[5];
        logic [31:0] a, pc;
        int          t, b0;
        tl = '{0, 1, 2, 3, 5};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", {63'h0, char_ready}, 64'h1);
        clear_expect();

        // Directed S1, then S3 plus S9 termination
        push_str("S1070100AABBCCDDE9\n");
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h100 + 32'(i));
        exp_data.push_back(32'hAA); exp_data.push_back(32'hBB);
        exp_data.push_back(32'hCC); exp_data.push_back(32'hDD);
        send_stream();
        check_eq("s1_err", {63'h0, err}, 64'h0);
        check_eq("s1_parse", {63'h0, srec_parse}, 64'h1);
        push_str("S30900001000DEADBEEFAE\nS9030100FB\n");
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h1000 + 32'(i));
        exp_data.push_back(32'hDE); exp_data.push_back(32'hAD);
        exp_data.push_back(32'hBE); exp_data.push_back(32'hEF);
        send_stream();
        compare_writes("dir");
        check_eq("dir_pc", {32'h0, start_pc}, 64'h100);
        check_eq("dir_done", {63'h0, done}, 64'h1);
        check_eq("dir_parse", {63'h0, srec_parse}, 64'h0);
        check_eq("dir_stall", {63'h0, stall}, 64'h0);

        // Random record streams with a random termination record
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 6; k++) begin
                t = tl[$urandom_range(0, 4)];
                build_rec(t, $urandom, $urandom_range(0, 8), $urandom_range(0, 1) == 1, a);
            end
            t = 7 + $urandom_range(0, 2);
            build_rec(t, $urandom, 0, $urandom_range(0, 1) == 1, pc);
            send_stream();
            compare_writes("rnd");
            check_eq("rnd_pc", {32'h0, start_pc}, {32'h0, pc});
            check_eq("rnd_done", {63'h0, done}, 64'h1);
            check_eq("rnd_err", {63'h0, err}, 64'h0);
            check_eq("rnd_stall", {63'h0, stall}, 64'h0);
            // After DONE further records are discarded
            clear_expect();
            build_rec(1, $urandom, 3, 1'b0, a);
            exp_addr.delete();
            exp_data.delete();
            send_stream();
            compare_writes("post_done");
            check_eq("post_done_pc", {32'h0, start_pc}, {32'h0, pc});
        end

        // Checksum error: bytes still written, then sticky error
        do_reset();
        push_str("S1070100AABBCCDDE8\n");
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h100 + 32'(i));
        exp_data.push_back(32'hAA); exp_data.push_back(32'hBB);
        exp_data.push_back(32'hCC); exp_data.push_back(32'hDD);
        send_stream();
        compare_writes("csum");
        check_eq("csum_err", {63'h0, err}, 64'h1);
        check_eq("csum_code", {62'h0, err_code}, 64'h1);
        check_eq("csum_stall", {63'h0, stall}, 64'h1);
        check_eq("csum_done", {63'h0, done}, 64'h0);
        clear_expect();
        push_str("S1070100AABBCCDDE9\n");
        send_stream();
        compare_writes("after_err");
        check_eq("after_err_code", {62'h0, err_code}, 64'h1);

        // Illegal character
        do_reset();
        send_char(8'h53); send_char(8'h31); send_char(8'h30);
        check_eq("illegal_pre_err", {63'h0, err}, 64'h0);
        send_char(8'h47);
        check_eq("illegal_err", {63'h0, err}, 64'h1);
        check_eq("illegal_code", {62'h0, err_code}, 64'h2);
        push_str("00AABBCCDDE9\n");
        send_stream();
        compare_writes("illegal");

        // Back-pressure: valid held high, CRLF, then end-of-stream
        do_reset();
        count_en = 1'b1;
        b0 = bubbles;
        for (int k = 0; k < 3; k++) build_rec(1, $urandom, $urandom_range(1, 6), 1'b1, a);
        stream_q.push_back(8'hFF);
        send_stream();
        count_en = 1'b0;
        compare_writes("bp");
        check_eq("bp_bubbles", 64'(bubbles - b0), 64'(exp_addr.size()));
        check_eq("bp_done", {63'h0, done}, 64'h1);
        check_eq("bp_pc", {32'h0, start_pc}, 64'h0);
        check_eq("bp_stall", {63'h0, stall}, 64'h0);

        // Reset during the WRITE cycle of the second byte
        do_reset();
        push_str("S1070100AABB");
        while (stream_q.size() > 0) send_char(stream_q.pop_front());
        check_eq("mid_rw", {63'h0, srec_rw}, 64'h1);
        check_eq("mid_addr", {32'h0, srec_address}, 64'h101);
        check_eq("mid_data", {32'h0, srec_data_in}, 64'hBB);
        rst = 1'b1;
        char_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("mid_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_expect();
        push_str("S1070100AABBCCDDE9\n");
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'h100 + 32'(i));
        exp_data.push_back(32'hAA); exp_data.push_back(32'hBB);
        exp_data.push_back(32'hCC); exp_data.push_back(32'hDD);
        send_stream();
        compare_writes("replay");
        check_eq("replay_err", {63'h0, err}, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/srec_loader.md
# srec_loader

Hardware SREC loader that replaces the testbench-side parser. It consumes an ASCII Motorola S-record stream one character at a time and issues byte writes to main memory over the processor's `srec_*` memory port. It holds the pipeline in stall until a termination record or the end-of-stream character is reached, then publishes the start PC. It sits between the character source (UART or bench) and the processor's memory/fetch control.

## Interface
- `ADDR_W`, default 32: memory address width and `start_pc` width.
- `DATA_W`, default 32: memory write-data width. The byte is placed in bits [7:0] and the upper bits are zero.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `char_valid`  in  1  a source character is present.
- `char_in`  in  8  ASCII character.
- `char_ready`  out  1  the loader accepts `char_in` on this edge.
- `srec_address`  out  ADDR_W  memory write address.
- `srec_data_in`  out  DATA_W  memory write data.
- `srec_access_size`  out  2  always 2'b00 (byte).
- `srec_rw`  out  1  one-cycle write strobe.
- `srec_parse`  out  1  high while loading.
- `stall`  out  1  fetch hold; equals `srec_parse | err`.
- `start_pc`  out  ADDR_W  entry address from the S7/S8/S9 record.
- `done`  out  1  load completed successfully; sticky.
- `err`  out  1  parse error; sticky.
- `err_code`  out  2  01 = checksum, 10 = illegal character, 11 = byte count too small.

## Operation
- A character is accepted on a rising edge where `char_valid & char_ready`.
- 0x0D is ignored in every state.
- Hex digits accepted: 0-9, A-F, a-f.
- States: IDLE, TYPE, CNT_HI, CNT_LO, ADDR, DATA, WRITE, CSUM, EOL, DONE, ERROR.
- **IDLE**
  - 'S' goes to TYPE.
  - 0x0A is ignored.
  - 0xFF (end of stream) goes to DONE with `start_pc` unchanged.
  - Any other character goes to ERROR with code 10.
- **TYPE**
  - Digit 0-9 is latched as the record type.
  - Address length in nibbles: 4 for types 0/1/5/9, 6 for types 2/8, 8 for types 3/7.
  - Types 4 and 6, or any non-digit, go to ERROR with code 10.
- **CNT_HI / CNT_LO**: byte count is captured MSB nibble first.
- **ADDR**
  - Address nibbles are shifted in MSB first and zero-extended to ADDR_W.
  - After the last address nibble:
    - remaining = count − address bytes − 1.
    - If count < address bytes + 1, go to ERROR with code 11.
    - If remaining = 0, go to CSUM; otherwise go to DATA.
- **DATA**
  - Two nibbles form one byte.
  - For types 1/2/3, the second nibble moves to WRITE.
  - For types 0/5 the byte is discarded and no write occurs.
  - `remaining` decrements per byte. Reaching 0 goes to CSUM.
- **WRITE** (exactly one cycle)
  - `srec_rw` = 1.
  - `srec_address` = record address + offset; offset resets to 0 per record and increments per byte.
  - `srec_data_in` = byte.
  - `char_ready` = 0.
  - Returns to DATA, or to CSUM if `remaining` = 0.
- **Checksum**
  - An 8-bit running sum covers the count byte, every address byte and every data byte, modulo 256.
  - In CSUM, the received byte must equal the one's complement of the sum; otherwise go to ERROR with code 01.
  - Bytes are written before the checksum is verified; a bad record still leaves its bytes in memory.
- **EOL**
  - 0x0A goes to IDLE, or to DONE if the type is 7/8/9. For types 7/8/9, `start_pc` is loaded with the record address.
  - Any other character goes to ERROR with code 10.
- **Terminal states**
  - DONE: `srec_parse` = 0, `done` = 1, `char_ready` = 1, further characters are discarded.
  - ERROR: `err` = 1, `srec_parse` stays 1, `char_ready` = 1, characters are discarded.
  - Only `rst` leaves DONE or ERROR.

## Timing
- **Values during reset and on the first cycle after reset**
  - `char_ready` = 0 during reset, 1 from the first cycle after.
  - `srec_address` = 0, `srec_data_in` = 0, `srec_access_size` = 00, `srec_rw` = 0.
  - `srec_parse` = 1, `stall` = 1.
  - `start_pc` = 0, `done` = 0, `err` = 0, `err_code` = 00.
- All outputs are registered.
- **Write latency**: the second data nibble is accepted at edge N. `srec_rw`, `srec_address` and `srec_data_in` are valid for the cycle between edge N and edge N+1. `srec_rw` falls at edge N+1.
- **Throughput**: one character per cycle, except a single `char_ready` = 0 bubble per written byte. The loader never drops a held `char_valid`.
- **Termination**: the terminating LF (or 0xFF) is accepted at edge N. `start_pc`, `done` and `srec_parse` = 0 take effect after edge N. `stall` drops in the same cycle.
- **Error**: `err`/`err_code` are set the cycle after the offending character is accepted.
- **Reset mid-record**: `rst` sampled high aborts immediately, including an in-flight WRITE (`srec_rw` = 0 next cycle). No partial state survives.

## Test plan
- **S1 record**: stream "S1070100AABBCCDDE9\n" -> four `srec_rw` pulses writing (0x0100,0xAA), (0x0101,0xBB), (0x0102,0xCC), (0x0103,0xDD) with access size 00; `err` = 0.
- **S3 record plus termination**: "S30900001000DEADBEEFAE\n" then "S9030100FB\n" -> writes 0x1000..0x1003 = DE,AD,BE,EF; then `start_pc` = 0x100, `done` = 1, `srec_parse` = 0, `stall` = 0.
- **Checksum error**: the S1 record with last byte E8 -> four writes occur, then `err` = 1, `err_code` = 01, `stall` stays 1; a later valid record produces no writes.
- **Illegal character**: "S10G..." -> `err_code` = 10 one cycle after the 'G' is accepted; no writes.
- **Back-pressure**: `char_valid` held high continuously with CRLF line endings -> `char_ready` low exactly one cycle per written byte; all bytes correct; 0xFF in IDLE gives `done` with `start_pc` = 0.
- **Reset mid-record**: assert `rst` during the WRITE cycle of the second byte -> next cycle `srec_rw` = 0 and all outputs at reset values; a replayed full record loads correctly.
